// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-mux
// select codes, the multi-cycle timer state type and a small helper that
// applies the M-over-W forwarding priority.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // The younger producer (M) wins over the older one (W).
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mc_timer.sv
// Occupancy timer for multi-cycle execute ops (mul/div). The op's first E
// cycle stalls combinationally; BUSY then covers the remaining MC_LAT-2 held
// cycles, so the op spends MC_LAT cycles in E in total. A one-cycle done flag
// keeps the op, still visible in E on its release cycle, from restarting.
module hazard_mc_timer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic start,     // multi-cycle op in E and not being redirected
  input  logic freeze,    // memory wait: hold all timer state
  output logic mc_stall,
  output logic mc_busy
);

  localparam bit HAS_STALL = (MC_LAT > 1);
  localparam int BUSY_CYC  = (MC_LAT > 2) ? MC_LAT - 2 : 0;
  localparam int CW        = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BUSY_CYC);
  localparam logic [CW-1:0] ONE  = CW'(1);

  mc_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;
  logic          first_cycle;

  assign first_cycle = HAS_STALL && (state_reg == IDLE) && start && !done_reg;
  assign mc_busy     = (state_reg == BUSY);
  assign mc_stall    = mc_busy || first_cycle;

  // Next-state logic: count down remaining BUSY cycles unless frozen.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    if (!freeze) begin
      done_next = 1'b0;
      case (state_reg)
        IDLE: begin
          if (first_cycle) begin
            if (BUSY_CYC == 0) begin
              done_next = 1'b1;   // MC_LAT==2: only the first cycle stalls
            end else begin
              state_next = BUSY;
              cnt_next   = LOAD;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == ONE) begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg - ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding (or stalling
// when forwarding is disabled), load-use stall, multi-cycle execute hold,
// data-memory wait freeze, control-flow flushes and saturating perf counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              MultiCycleE,
  input  logic              PCSrcE,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A producer only matters if it writes a non-zero destination.
  function automatic logic hit(input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rd,
                               input logic              we);
    return we && (rd != '0) && (rs == rd);
  endfunction

  logic [REG_AW-1:0] rs_e [2];
  logic [REG_AW-1:0] rs_d [2];
  logic [1:0]        fwd_sel [2];
  logic              raw_src [2];
  logic              lw_src  [2];

  logic mem_stall, lw_stall, raw_stall, mc_stall, mc_busy;
  logic stall_f, stall_e, flush_d, flush_e, flush_m, flush_w, flush_any;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;
  assign rs_d[0] = Rs1D;
  assign rs_d[1] = Rs2D;

  // Per-operand forwarding select and D-stage dependence detection.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign fwd_sel[gi] = (FWD_EN != 0)
                         ? fwd_pick(hit(rs_e[gi], RdM, RegWriteM), hit(rs_e[gi], RdW, RegWriteW))
                         : FWD_RF;
      assign raw_src[gi] = hit(rs_d[gi], RdE, RegWriteE) ||
                           hit(rs_d[gi], RdM, RegWriteM) ||
                           hit(rs_d[gi], RdW, RegWriteW);
      assign lw_src[gi]  = hit(rs_d[gi], RdE, RegWriteE);
    end
  endgenerate

  assign mem_stall = !MemReadyM;
  assign lw_stall  = ResultSrcE && (lw_src[0] || lw_src[1]);
  assign raw_stall = (FWD_EN == 0) && (raw_src[0] || raw_src[1]);

  hazard_mc_timer #(
    .MC_LAT (MC_LAT)
  ) u_mc_timer (
    .clk      (clk),
    .srst     (rst),
    .start    (MultiCycleE && !PCSrcE),
    .freeze   (mem_stall),
    .mc_stall (mc_stall),
    .mc_busy  (mc_busy)
  );

  // Memory wait dominates: it holds F..M, bubbles W and masks all other flushes.
  assign stall_f   = mem_stall || mc_stall || lw_stall || raw_stall;
  assign stall_e   = mem_stall || mc_stall;
  assign flush_d   = PCSrcE && !stall_e;
  assign flush_e   = (PCSrcE || lw_stall || raw_stall) && !stall_e;
  assign flush_m   = mc_stall && !mem_stall;
  assign flush_w   = mem_stall;
  assign flush_any = flush_d || flush_e || flush_m || flush_w;

  // Output drive; while in reset, hold every stage flushed and nothing stalled.
  always_comb begin
    StallF    = stall_f;
    StallD    = stall_f;
    StallE    = stall_e;
    StallM    = mem_stall;
    FlushD    = flush_d;
    FlushE    = flush_e;
    FlushM    = flush_m;
    FlushW    = flush_w;
    ForwardAE = fwd_sel[0];
    ForwardBE = fwd_sel[1];
    McBusy    = mc_busy;
    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      McBusy    = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_f && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_any && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign StallCycles = stall_cnt_reg;
  assign FlushEvents = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances share one stimulus stream,
// one with forwarding (8-bit counters), one without (4-bit counters). A
// behavioural model tracks how long a multi-cycle op has sat in E and
// derives every expected output from the hazard rules directly.
module tb_hazard_scoreboard_unit;

  localparam int MC_LAT = 4;
  localparam int MAX_A  = 255;
  localparam int MAX_B  = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MultiCycleE, PCSrcE, MemReadyM;

  logic a_StallF, a_StallD, a_StallE, a_StallM, a_FlushD, a_FlushE, a_FlushM, a_FlushW, a_McBusy;
  logic [1:0] a_ForwardAE, a_ForwardBE;
  logic [7:0] a_StallCycles, a_FlushEvents;
  logic b_StallF, b_StallD, b_StallE, b_StallM, b_FlushD, b_FlushE, b_FlushM, b_FlushW, b_McBusy;
  logic [1:0] b_ForwardAE, b_ForwardBE;
  logic [3:0] b_StallCycles, b_FlushEvents;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(5), .MC_LAT(MC_LAT), .FWD_EN(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE),
    .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
    .StallF(a_StallF), .StallD(a_StallD), .StallE(a_StallE), .StallM(a_StallM),
    .FlushD(a_FlushD), .FlushE(a_FlushE), .FlushM(a_FlushM), .FlushW(a_FlushW),
    .ForwardAE(a_ForwardAE), .ForwardBE(a_ForwardBE), .McBusy(a_McBusy),
    .StallCycles(a_StallCycles), .FlushEvents(a_FlushEvents));

  hazard_scoreboard_unit #(.REG_AW(5), .MC_LAT(MC_LAT), .FWD_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE),
    .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
    .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE), .StallM(b_StallM),
    .FlushD(b_FlushD), .FlushE(b_FlushE), .FlushM(b_FlushM), .FlushW(b_FlushW),
    .ForwardAE(b_ForwardAE), .ForwardBE(b_ForwardBE), .McBusy(b_McBusy),
    .StallCycles(b_StallCycles), .FlushEvents(b_FlushEvents));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: is a multi-cycle op parked in E, and for how many advancing cycles.
  bit holding = 0;
  int age     = 0;
  int sc[2];
  int fe[2];

  // Expected outputs, index 0 = forwarding instance, 1 = stalling instance.
  bit e_sf[2], e_se[2], e_sm[2], e_fd[2], e_fe[2], e_fm[2], e_fw[2], e_busy[2];
  bit [1:0] e_fa[2], e_fb[2];
  bit n_sf[2], n_fany[2];   // non-reset values feeding the counters
  bit m_mcs, m_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return (we === 1'b1) && (rd != 5'd0) && (rs == rd);
  endfunction

  function automatic bit [1:0] fsel(input logic [4:0] rs);
    if (hit(rs, RdM, RegWriteM)) return 2'b10;
    if (hit(rs, RdW, RegWriteW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic quiet();
    rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
    MultiCycleE = 0; PCSrcE = 0; MemReadyM = 1;
  endtask

  // Settle the inputs, predict every output, compare both instances.
  task automatic evaluate();
    bit lw, raw, busy;
    if (holding) MultiCycleE = 1'b1;
    #2;
    m_mem = !MemReadyM;
    lw    = ResultSrcE && (hit(Rs1D, RdE, RegWriteE) || hit(Rs2D, RdE, RegWriteE));
    m_mcs = MultiCycleE && (age < MC_LAT - 1) && !(age == 0 && PCSrcE);
    busy  = (age >= 1) && (age <= MC_LAT - 2);
    for (int c = 0; c < 2; c++) begin
      raw = (c == 1) && (hit(Rs1D, RdE, RegWriteE) || hit(Rs1D, RdM, RegWriteM) ||
                         hit(Rs1D, RdW, RegWriteW) || hit(Rs2D, RdE, RegWriteE) ||
                         hit(Rs2D, RdM, RegWriteM) || hit(Rs2D, RdW, RegWriteW));
      e_sf[c]   = m_mem || m_mcs || lw || raw;
      e_se[c]   = m_mem || m_mcs;
      e_sm[c]   = m_mem;
      e_fd[c]   = PCSrcE && !e_se[c];
      e_fe[c]   = (PCSrcE || lw || raw) && !e_se[c];
      e_fm[c]   = m_mcs && !m_mem;
      e_fw[c]   = m_mem;
      e_busy[c] = busy;
      e_fa[c]   = (c == 0) ? fsel(Rs1E) : 2'b00;
      e_fb[c]   = (c == 0) ? fsel(Rs2E) : 2'b00;
      n_sf[c]   = e_sf[c];
      n_fany[c] = e_fd[c] || e_fe[c] || e_fm[c] || e_fw[c];
      if (rst) begin
        e_sf[c] = 0; e_se[c] = 0; e_sm[c] = 0; e_busy[c] = 0;
        e_fd[c] = 1; e_fe[c] = 1; e_fm[c] = 1; e_fw[c] = 1;
        e_fa[c] = 0; e_fb[c] = 0;
      end
    end
    chk("a_StallF", a_StallF, e_sf[0]);   chk("b_StallF", b_StallF, e_sf[1]);
    chk("a_StallD", a_StallD, e_sf[0]);   chk("b_StallD", b_StallD, e_sf[1]);
    chk("a_StallE", a_StallE, e_se[0]);   chk("b_StallE", b_StallE, e_se[1]);
    chk("a_StallM", a_StallM, e_sm[0]);   chk("b_StallM", b_StallM, e_sm[1]);
    chk("a_FlushD", a_FlushD, e_fd[0]);   chk("b_FlushD", b_FlushD, e_fd[1]);
    chk("a_FlushE", a_FlushE, e_fe[0]);   chk("b_FlushE", b_FlushE, e_fe[1]);
    chk("a_FlushM", a_FlushM, e_fm[0]);   chk("b_FlushM", b_FlushM, e_fm[1]);
    chk("a_FlushW", a_FlushW, e_fw[0]);   chk("b_FlushW", b_FlushW, e_fw[1]);
    chk("a_McBusy", a_McBusy, e_busy[0]); chk("b_McBusy", b_McBusy, e_busy[1]);
    chk("a_FwdA", a_ForwardAE, e_fa[0]);  chk("b_FwdA", b_ForwardAE, e_fa[1]);
    chk("a_FwdB", a_ForwardBE, e_fb[0]);  chk("b_FwdB", b_ForwardBE, e_fb[1]);
    chk("a_StallCycles", a_StallCycles, sc[0]); chk("b_StallCycles", b_StallCycles, sc[1]);
    chk("a_FlushEvents", a_FlushEvents, fe[0]); chk("b_FlushEvents", b_FlushEvents, fe[1]);
  endtask

  // Advance one clock and update the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      holding = 0; age = 0;
      sc[0] = 0; sc[1] = 0; fe[0] = 0; fe[1] = 0;
    end else begin
      if (n_sf[0]   && sc[0] < MAX_A) sc[0]++;
      if (n_sf[1]   && sc[1] < MAX_B) sc[1]++;
      if (n_fany[0] && fe[0] < MAX_A) fe[0]++;
      if (n_fany[1] && fe[1] < MAX_B) fe[1]++;
      if (!m_mem) begin
        if (MultiCycleE && m_mcs) begin holding = 1; age++; end
        else begin holding = 0; age = 0; end
      end else if (MultiCycleE) begin
        holding = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_e_cnt;
    sc[0] = 0; sc[1] = 0; fe[0] = 0; fe[1] = 0;
    quiet();
    rst = 1;
    @(negedge clk);

    // Reset behaviour
    evaluate();
    chk("rst_StallF", a_StallF, 1'b0); chk("rst_FlushD", a_FlushD, 1'b1);
    chk("rst_FlushW", b_FlushW, 1'b1); chk("rst_McBusy", a_McBusy, 1'b0);
    tick();
    quiet(); evaluate(); chk("rst_cnt", a_StallCycles, 0); tick();
    $display("step reset done");

    // Forwarding priority
    quiet(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    evaluate(); chk("fwd_m_pri", a_ForwardAE, 2'b10); chk("fwd_disabled", b_ForwardAE, 2'b00); tick();
    quiet(); RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; Rs1E = 0;
    evaluate(); chk("fwd_x0", a_ForwardAE, 2'b00); tick();
    quiet(); RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1; Rs1E = 5;
    evaluate(); chk("fwd_w", a_ForwardAE, 2'b01); tick();
    $display("step forwarding done");

    // Load-use
    quiet(); ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
    evaluate(); chk("lu_StallF", a_StallF, 1'b1); chk("lu_FlushE", a_FlushE, 1'b1);
    chk("lu_StallE", a_StallE, 1'b0); tick();
    quiet(); RdW = 7; RegWriteW = 1; Rs2E = 7;
    evaluate(); chk("lu_fwdB", a_ForwardBE, 2'b01); tick();
    quiet(); ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs2D = 0;
    evaluate(); chk("lu_x0", a_StallF, 1'b0); tick();
    $display("step load-use done");

    // Multi-cycle op occupies E for MC_LAT cycles
    quiet(); rst = 1; evaluate(); tick();
    for (int i = 0; i < 4; i++) begin
      quiet(); MultiCycleE = 1;
      evaluate();
      chk("mc_StallE", a_StallE, i < 3);
      chk("mc_McBusy", a_McBusy, (i == 1) || (i == 2));
      chk("mc_FlushM", a_FlushM, i < 3);
      tick();
    end
    quiet(); evaluate(); chk("mc_StallCycles", a_StallCycles, 3); tick();
    $display("step multi-cycle done");

    // Memory wait inside BUSY, with a redirect pending
    stall_e_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      quiet(); MultiCycleE = (i == 0);
      if (i == 2 || i == 3) begin MemReadyM = 0; PCSrcE = 1; end
      evaluate();
      if (a_StallE === 1'b1) stall_e_cnt++;
      if (i == 2 || i == 3) begin
        chk("mw_StallF", a_StallF, 1'b1); chk("mw_StallM", a_StallM, 1'b1);
        chk("mw_FlushW", a_FlushW, 1'b1); chk("mw_FlushD", a_FlushD, 1'b0);
        chk("mw_FlushE", a_FlushE, 1'b0); chk("mw_FlushM", a_FlushM, 1'b0);
      end
      tick();
    end
    chk("mw_stallE_cycles", stall_e_cnt, 5);
    $display("step memory-wait done");

    // Forwarding disabled resolves RAW by stalling D
    quiet(); RdM = 3; RegWriteM = 1; Rs1D = 3;
    evaluate();
    chk("nofwd_StallD", b_StallD, 1'b1); chk("nofwd_FlushE", b_FlushE, 1'b1);
    chk("nofwd_FwdA", b_ForwardAE, 2'b00); chk("fwd_no_stall", a_StallD, 1'b0);
    tick();
    $display("step forwarding-disabled done");

    // Counter saturation
    quiet(); rst = 1; evaluate(); tick();
    for (int i = 0; i < 20; i++) begin
      quiet(); ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs1D = 7;
      evaluate(); tick();
    end
    quiet(); evaluate();
    chk("sat_b_StallCycles", b_StallCycles, 15); chk("a_StallCycles_20", a_StallCycles, 20);
    tick();
    $display("step saturation done");

    // Reset mid-BUSY
    quiet(); MultiCycleE = 1; evaluate(); tick();
    quiet(); evaluate(); chk("midrst_busy", a_McBusy, 1'b1); tick();
    quiet(); rst = 1; evaluate(); tick();
    quiet(); evaluate();
    chk("midrst_McBusy", a_McBusy, 1'b0); chk("midrst_StallE", a_StallE, 1'b0);
    chk("midrst_StallCycles", a_StallCycles, 0); chk("midrst_FlushEvents", a_FlushEvents, 0);
    tick();
    $display("step reset-mid-busy done");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      quiet();
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteE   = 1'($urandom_range(0, 1));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE  = ($urandom_range(0, 3) == 0);
      MultiCycleE = ($urandom_range(0, 4) == 0);
      PCSrcE      = ($urandom_range(0, 5) == 0);
      MemReadyM   = ($urandom_range(0, 4) != 0);
      rst         = ($urandom_range(0, 59) == 0);
      evaluate();
      tick();
    end
    $display("step random done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
